// File: rtl/data_memory_controller_if.sv
// Data-memory req/ack bus: the controller drives the request side as master, memory answers as slave.
interface data_memory_controller_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic                  bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/data_memory_controller.sv
// MEM-stage load/store responder: request to bus_req in 1 cycle, done 1 cycle after ack or timeout.
// Pipeline is held via combinational stall until the COMPLETE cycle.
module data_memory_controller #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  stall,
    output logic                  done,
    output logic                  error,
    data_memory_controller_if.master bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t                state, state_nxt;
    logic [7:0]            cnt, cnt_nxt;
    logic                  req_nxt, we_nxt, done_nxt, error_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt, rdata_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            rdata         <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            bus.bus_req   <= req_nxt;
            bus.bus_we    <= we_nxt;
            bus.bus_addr  <= addr_nxt;
            bus.bus_wdata <= wdata_nxt;
            rdata         <= rdata_nxt;
            done          <= done_nxt;
            error         <= error_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_nxt   = bus.bus_req;
        we_nxt    = bus.bus_we;
        addr_nxt  = bus.bus_addr;
        wdata_nxt = bus.bus_wdata;
        rdata_nxt = rdata;
        done_nxt  = 1'b0;
        error_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read ^ mem_write) begin
                    addr_nxt  = address;
                    wdata_nxt = wdata;
                    we_nxt    = mem_write;
                    req_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ACCESS;
                end else if (mem_read && mem_write) begin
                    // Conflicting strobes: report the fault without touching the bus.
                    done_nxt  = 1'b1;
                    error_nxt = 1'b1;
                    state_nxt = COMPLETE;
                end
            end
            ACCESS: begin
                if (bus.bus_ack) begin
                    req_nxt   = 1'b0;
                    if (!bus.bus_we) rdata_nxt = bus.bus_rdata;
                    done_nxt  = 1'b1;
                    state_nxt = COMPLETE;
                end else if (cnt == CNT_LAST) begin
                    req_nxt   = 1'b0;
                    if (!bus.bus_we) rdata_nxt = '1;
                    done_nxt  = 1'b1;
                    error_nxt = 1'b1;
                    state_nxt = COMPLETE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            COMPLETE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // A strobe still held in COMPLETE does not stall, so the pipeline advances past it.
    assign stall = !reset && (((state == IDLE) && (mem_read || mem_write)) || (state == ACCESS));
endmodule

// File: tb/tb_data_memory_controller.sv
module tb_data_memory_controller;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          stall, done, error;

    data_memory_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    data_memory_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .address   (address),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .done      (done),
        .error     (error),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected completions, produced by the driver and consumed by the monitor.
    typedef struct {
        int            cyc;
        logic [DW-1:0] rdata;
        logic          error;
    } exp_t;
    exp_t sbq[$];

    // Slave model: acks in the ack_delay-th cycle of a request; delay beyond TO means never.
    int            ack_delay = 0;
    int            req_cnt = 0;
    logic [DW-1:0] rd_val = '0;
    bit            late_ack = 1'b0;

    initial begin
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = '0;
    end

    always @(negedge clk) begin
        if (bus_if.bus_req) req_cnt = req_cnt + 1;
        else                req_cnt = 0;
        bus_if.bus_ack   = late_ack || (bus_if.bus_req && (req_cnt == ack_delay));
        bus_if.bus_rdata = bus_if.bus_ack ? rd_val : DW'($urandom);
    end

    // Expected activity window of the current transaction.
    int            win_start = 0;
    int            win_end = -1;
    bit            win_illegal = 1'b0;
    bit            win_chk = 1'b1;
    logic          exp_we = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0;

    always @(negedge clk) begin
        if (!reset && win_chk) begin
            chk("stall", 32'(stall), 32'((cyc >= win_start) && (cyc <= win_end)));
            chk("bus_req", 32'(bus_if.bus_req),
                32'((cyc >= win_start + 1) && (cyc <= win_end) && !win_illegal));
            if (bus_if.bus_req) begin
                chk("bus_we", 32'(bus_if.bus_we), 32'(exp_we));
                chk("bus_addr", 32'(bus_if.bus_addr), 32'(exp_addr));
                chk("bus_wdata", 32'(bus_if.bus_wdata), 32'(exp_wdata));
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_done: done=1 with nothing outstanding (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rdata", 32'(rdata), 32'(e.rdata));
                    chk("error", 32'(error), 32'(e.error));
                end
            end
        end
    end

    logic [DW-1:0] rdata_m = '0;

    // op: 0 read, 1 write, 2 both strobes. Entered and left at posedge+1.
    task automatic run_txn(input int op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input int d, input logic [DW-1:0] rv, input int gap, input bit hold);
        exp_t e;
        int   lat;
        int   n;
        if (gap > 0) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        if (op == 2) begin
            lat     = 1;
            e.error = 1'b1;
        end else if (d <= TO) begin
            lat     = d + 1;
            e.error = 1'b0;
            if (op == 0) rdata_m = rv;
        end else begin
            lat     = TO + 1;
            e.error = 1'b1;
            if (op == 0) rdata_m = '1;
        end
        e.rdata = rdata_m;
        e.cyc   = cyc + lat;
        sbq.push_back(e);
        win_start   = cyc;
        win_end     = cyc + lat - 1;
        win_illegal = (op == 2);
        if (op != 2) begin
            exp_we    = (op == 1);
            exp_addr  = a;
            exp_wdata = wd;
        end
        ack_delay = d;
        rd_val    = rv;
        mem_read  = (op != 1);
        mem_write = (op != 0);
        address   = a;
        wdata     = wd;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n = n + 1;
        end while (!done && n < 40);
        if (!done) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL txn_timeout: no done within %0d cycles (op %0d)", n, op);
        end
        if (!hold) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit prev_hold;
        bit h;
        int op;
        int g;
        mem_read = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_if.bus_we), 32'd0);
        chk("rst_bus_addr", 32'(bus_if.bus_addr), 32'd0);
        chk("rst_bus_wdata", 32'(bus_if.bus_wdata), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #1;

        run_txn(0, 16'h0100, 8'h00, 1, 8'h5A, 0, 1'b0);
        run_txn(1, 16'h0060, 8'hC3, 4, 8'h11, 1, 1'b0);
        run_txn(0, 16'h1234, 8'h00, TO + 2, 8'h22, 0, 1'b0);
        run_txn(0, 16'h2000, 8'h00, 2, 8'h77, 0, 1'b0);
        run_txn(0, 16'h0300, 8'h00, 1, 8'h33, 0, 1'b1);
        run_txn(0, 16'h0300, 8'h00, 2, 8'h44, 0, 1'b0);
        run_txn(2, 16'h0400, 8'h99, 1, 8'h55, 2, 1'b0);
        run_txn(1, 16'h0500, 8'h66, TO + 1, 8'h00, 0, 1'b0);

        prev_hold = 1'b0;
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 9));
            op = (op < 5) ? 0 : ((op < 9) ? 1 : 2);
            g  = prev_hold ? 0 : int'($urandom_range(0, 2));
            h  = ($urandom_range(0, 3) == 0);
            run_txn(op, AW'($urandom), DW'($urandom), int'($urandom_range(1, TO + 2)),
                    DW'($urandom), g, h);
            prev_hold = h;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Reset during an unacked read; a late ack must then be ignored.
        win_chk   = 1'b0;
        ack_delay = TO + 10;
        address   = 16'h0ABC;
        mem_read  = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("mid_bus_req_before_rst", 32'(bus_if.bus_req), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_rst_bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_error", 32'(error), 32'd0);
        chk("mid_rst_rdata", 32'(rdata), 32'd0);
        chk("mid_rst_bus_addr", 32'(bus_if.bus_addr), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_read  = 1'b0;
        rdata_m   = '0;
        late_ack  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("late_ack_bus_req", 32'(bus_if.bus_req), 32'd0);
            chk("late_ack_done", 32'(done), 32'd0);
            chk("late_ack_stall", 32'(stall), 32'd0);
        end
        late_ack = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        win_end = -1;
        win_chk = 1'b1;
        run_txn(0, 16'h0042, 8'h00, 3, 8'hA5, 0, 1'b0);
        run_txn(1, 16'h0043, 8'h3C, 1, 8'h00, 0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
